// File: rtl/ahb_slave_mux_system.sv
// ahb_slave_mux_system: AHB-Lite data-phase response multiplexer with built-in
// default slave (two-cycle ERROR for unmapped accesses).
`default_nettype none

module ahb_slave_mux_system #(
   parameter int            DW        = 32,
   parameter logic [DW-1:0] DEF_RDATA = '0
) (
   input  logic          HCLK,
   input  logic          HRESETn,
   input  logic [1:0]    HTRANS,
   input  logic          HSEL_RAM,
   input  logic          HSEL_APB,
   input  logic          HSEL_CM3_ADC,
   input  logic          HSEL_CM3_FFT,
   input  logic          HSEL_CM3_MAC,
   input  logic          HSEL_CM3_MAC_1,
   input  logic          HSEL_CM3_LOG,
   input  logic          HSEL_DefSlave,
   input  logic          HREADYOUT_RAM,
   input  logic          HREADYOUT_APB,
   input  logic          HREADYOUT_CM3_ADC,
   input  logic          HREADYOUT_CM3_FFT,
   input  logic          HREADYOUT_CM3_MAC,
   input  logic          HREADYOUT_CM3_MAC_1,
   input  logic          HREADYOUT_CM3_LOG,
   input  logic          HRESP_RAM,
   input  logic          HRESP_APB,
   input  logic          HRESP_CM3_ADC,
   input  logic          HRESP_CM3_FFT,
   input  logic          HRESP_CM3_MAC,
   input  logic          HRESP_CM3_MAC_1,
   input  logic          HRESP_CM3_LOG,
   input  logic [DW-1:0] HRDATA_RAM,
   input  logic [DW-1:0] HRDATA_APB,
   input  logic [DW-1:0] HRDATA_CM3_ADC,
   input  logic [DW-1:0] HRDATA_CM3_FFT,
   input  logic [DW-1:0] HRDATA_CM3_MAC,
   input  logic [DW-1:0] HRDATA_CM3_MAC_1,
   input  logic [DW-1:0] HRDATA_CM3_LOG,
   output logic          HREADY,
   output logic          HRESP,
   output logic [DW-1:0] HRDATA
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ERR1 = 2'd1,
      ST_ERR2 = 2'd2
   } def_state_e;

   localparam logic [3:0] SEL_NONE = 4'b0000;

   // sel_q = {valid, index}; index 7 is the default slave
   logic [3:0]    sel_q, sel_d;
   def_state_e    state_q, state_d;
   logic          def_ready, def_resp;
   logic          accept;
   logic [7:0]    slv_ready, slv_resp;
   logic [DW-1:0] slv_rdata [8];
   logic          unused_htrans0;

   assign unused_htrans0 = HTRANS[0];

   assign slv_ready = {def_ready, HREADYOUT_CM3_LOG, HREADYOUT_CM3_MAC_1, HREADYOUT_CM3_MAC,
                       HREADYOUT_CM3_FFT, HREADYOUT_CM3_ADC, HREADYOUT_APB, HREADYOUT_RAM};
   assign slv_resp  = {def_resp, HRESP_CM3_LOG, HRESP_CM3_MAC_1, HRESP_CM3_MAC,
                       HRESP_CM3_FFT, HRESP_CM3_ADC, HRESP_APB, HRESP_RAM};

   assign slv_rdata[0] = HRDATA_RAM;
   assign slv_rdata[1] = HRDATA_APB;
   assign slv_rdata[2] = HRDATA_CM3_ADC;
   assign slv_rdata[3] = HRDATA_CM3_FFT;
   assign slv_rdata[4] = HRDATA_CM3_MAC;
   assign slv_rdata[5] = HRDATA_CM3_MAC_1;
   assign slv_rdata[6] = HRDATA_CM3_LOG;
   assign slv_rdata[7] = DEF_RDATA;

   // Priority encode; a stalled data phase keeps its selection
   always_comb begin
      sel_d = sel_q;
      if (HREADY) begin
         if      (HSEL_RAM)       sel_d = {1'b1, 3'd0};
         else if (HSEL_APB)       sel_d = {1'b1, 3'd1};
         else if (HSEL_CM3_ADC)   sel_d = {1'b1, 3'd2};
         else if (HSEL_CM3_FFT)   sel_d = {1'b1, 3'd3};
         else if (HSEL_CM3_MAC)   sel_d = {1'b1, 3'd4};
         else if (HSEL_CM3_MAC_1) sel_d = {1'b1, 3'd5};
         else if (HSEL_CM3_LOG)   sel_d = {1'b1, 3'd6};
         else if (HSEL_DefSlave)  sel_d = {1'b1, 3'd7};
         else                     sel_d = SEL_NONE;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         sel_q   <= SEL_NONE;
         state_q <= ST_IDLE;
      end else begin
         sel_q   <= sel_d;
         state_q <= state_d;
      end
   end

   assign accept = HSEL_DefSlave & HREADY & HTRANS[1];

   always_comb begin
      state_d   = ST_IDLE;
      def_ready = 1'b1;
      def_resp  = 1'b0;
      case (state_q)
         ST_IDLE: state_d = accept ? ST_ERR1 : ST_IDLE;
         ST_ERR1: begin
            def_ready = 1'b0;
            def_resp  = 1'b1;
            state_d   = ST_ERR2;
         end
         ST_ERR2: begin
            def_resp = 1'b1;
            state_d  = accept ? ST_ERR1 : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      HREADY = 1'b1;
      HRESP  = 1'b0;
      HRDATA = DEF_RDATA;
      if (sel_q[3]) begin
         HREADY = slv_ready[sel_q[2:0]];
         HRESP  = slv_resp[sel_q[2:0]];
         HRDATA = slv_rdata[sel_q[2:0]];
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ahb_slave_mux_system.sv
// tb_ahb_slave_mux_system: directed vector table plus reset/back-to-back sequences.
`default_nettype none

module tb_ahb_slave_mux_system;

   localparam logic [31:0] DEFD = 32'h0;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic [1:0]  HTRANS;
   logic [7:0]  hsel;
   logic [6:0]  rdy, rsp;
   logic [31:0] rdata [7];
   logic        HREADY, HRESP;
   logic [31:0] HRDATA;

   int checks = 0;
   int errors = 0;

   always #5 HCLK = ~HCLK;

   ahb_slave_mux_system #(.DW(32), .DEF_RDATA(DEFD)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HTRANS(HTRANS),
      .HSEL_RAM(hsel[0]), .HSEL_APB(hsel[1]), .HSEL_CM3_ADC(hsel[2]), .HSEL_CM3_FFT(hsel[3]),
      .HSEL_CM3_MAC(hsel[4]), .HSEL_CM3_MAC_1(hsel[5]), .HSEL_CM3_LOG(hsel[6]),
      .HSEL_DefSlave(hsel[7]),
      .HREADYOUT_RAM(rdy[0]), .HREADYOUT_APB(rdy[1]), .HREADYOUT_CM3_ADC(rdy[2]),
      .HREADYOUT_CM3_FFT(rdy[3]), .HREADYOUT_CM3_MAC(rdy[4]), .HREADYOUT_CM3_MAC_1(rdy[5]),
      .HREADYOUT_CM3_LOG(rdy[6]),
      .HRESP_RAM(rsp[0]), .HRESP_APB(rsp[1]), .HRESP_CM3_ADC(rsp[2]), .HRESP_CM3_FFT(rsp[3]),
      .HRESP_CM3_MAC(rsp[4]), .HRESP_CM3_MAC_1(rsp[5]), .HRESP_CM3_LOG(rsp[6]),
      .HRDATA_RAM(rdata[0]), .HRDATA_APB(rdata[1]), .HRDATA_CM3_ADC(rdata[2]),
      .HRDATA_CM3_FFT(rdata[3]), .HRDATA_CM3_MAC(rdata[4]), .HRDATA_CM3_MAC_1(rdata[5]),
      .HRDATA_CM3_LOG(rdata[6]),
      .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
   );

   typedef struct {
      logic [7:0]  sel;
      logic [1:0]  trans;
      logic [6:0]  rdy;
      logic [6:0]  rsp;
      logic        e_rdy;
      logic        e_rsp;
      logic [31:0] e_data;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic [7:0] s, logic [1:0] t, logic [6:0] r, logic [6:0] p,
                               logic er, logic ep, logic [31:0] ed);
      vec_t v;
      v.sel = s; v.trans = t; v.rdy = r; v.rsp = p;
      v.e_rdy = er; v.e_rsp = ep; v.e_data = ed;
      return v;
   endfunction

   task automatic drive(logic [7:0] s, logic [1:0] t, logic [6:0] r, logic [6:0] p);
      hsel = s; HTRANS = t; rdy = r; rsp = p;
   endtask

   task automatic check(string nm, logic er, logic ep, logic [31:0] ed);
      checks++;
      if (HREADY !== er || HRESP !== ep || HRDATA !== ed) begin
         errors++;
         $display("FAIL %s: got HREADY=%b HRESP=%b HRDATA=%h, expected HREADY=%b HRESP=%b HRDATA=%h",
                  nm, HREADY, HRESP, HRDATA, er, ep, ed);
      end
   endtask

   // Slave indices: 0 RAM, 1 APB, 2 ADC, 3 FFT, 4 MAC, 5 MAC_1, 6 LOG, bit 7 of sel = DefSlave
   initial begin
      rdata[0] = 32'hDEADBEEF;
      for (int i = 1; i < 7; i++) rdata[i] = 32'hA000_0000 | i;

      // Each vector: inputs for this cycle, outputs expected in this same cycle
      vecs.push_back(mk(8'h00, 2'b00, 7'h7F, 7'h00, 1, 0, DEFD));
      vecs.push_back(mk(8'h01, 2'b10, 7'h7F, 7'h00, 1, 0, DEFD));          // RAM addr
      vecs.push_back(mk(8'h00, 2'b00, 7'h7F, 7'h00, 1, 0, 32'hDEADBEEF));  // RAM data
      vecs.push_back(mk(8'h02, 2'b10, 7'h7F, 7'h00, 1, 0, DEFD));          // APB addr
      vecs.push_back(mk(8'h01, 2'b10, 7'h7D, 7'h00, 0, 0, 32'hA000_0001)); // APB wait x3
      vecs.push_back(mk(8'h01, 2'b10, 7'h7D, 7'h00, 0, 0, 32'hA000_0001));
      vecs.push_back(mk(8'h01, 2'b10, 7'h7D, 7'h00, 0, 0, 32'hA000_0001));
      vecs.push_back(mk(8'h01, 2'b10, 7'h7F, 7'h00, 1, 0, 32'hA000_0001)); // RAM accepted
      vecs.push_back(mk(8'h00, 2'b00, 7'h7F, 7'h00, 1, 0, 32'hDEADBEEF));
      vecs.push_back(mk(8'h80, 2'b10, 7'h7F, 7'h00, 1, 0, DEFD));          // unmapped NONSEQ
      vecs.push_back(mk(8'h00, 2'b00, 7'h7F, 7'h00, 0, 1, DEFD));          // ERR1
      vecs.push_back(mk(8'h00, 2'b00, 7'h7F, 7'h00, 1, 1, DEFD));          // ERR2
      vecs.push_back(mk(8'h00, 2'b00, 7'h7F, 7'h00, 1, 0, DEFD));
      vecs.push_back(mk(8'h80, 2'b00, 7'h7F, 7'h00, 1, 0, DEFD));          // unmapped IDLE
      vecs.push_back(mk(8'h00, 2'b00, 7'h7F, 7'h00, 1, 0, DEFD));          // zero-wait OKAY
      vecs.push_back(mk(8'h80, 2'b10, 7'h7F, 7'h00, 1, 0, DEFD));          // back-to-back
      vecs.push_back(mk(8'h80, 2'b10, 7'h7F, 7'h00, 0, 1, DEFD));
      vecs.push_back(mk(8'h80, 2'b10, 7'h7F, 7'h00, 1, 1, DEFD));
      vecs.push_back(mk(8'h00, 2'b00, 7'h7F, 7'h00, 0, 1, DEFD));
      vecs.push_back(mk(8'h00, 2'b00, 7'h7F, 7'h00, 1, 1, DEFD));
      vecs.push_back(mk(8'h44, 2'b10, 7'h7F, 7'h00, 1, 0, DEFD));          // LOG+ADC
      vecs.push_back(mk(8'h08, 2'b10, 7'h7F, 7'h00, 1, 0, 32'hA000_0002)); // ADC routed
      vecs.push_back(mk(8'h00, 2'b00, 7'h77, 7'h08, 0, 1, 32'hA000_0003)); // FFT ERR c1
      vecs.push_back(mk(8'h00, 2'b00, 7'h7F, 7'h08, 1, 1, 32'hA000_0003)); // FFT ERR c2
      vecs.push_back(mk(8'hFF, 2'b10, 7'h7F, 7'h00, 1, 0, DEFD));          // all selects
      vecs.push_back(mk(8'h10, 2'b10, 7'h7F, 7'h00, 1, 0, 32'hDEADBEEF));  // RAM wins
      vecs.push_back(mk(8'h20, 2'b10, 7'h7F, 7'h00, 1, 0, 32'hA000_0004));
      vecs.push_back(mk(8'h40, 2'b10, 7'h7F, 7'h00, 1, 0, 32'hA000_0005));
      vecs.push_back(mk(8'h00, 2'b00, 7'h7F, 7'h00, 1, 0, 32'hA000_0006));
      vecs.push_back(mk(8'h00, 2'b00, 7'h7F, 7'h00, 1, 0, DEFD));

      HRESETn = 1'b0;
      drive(8'h00, 2'b00, 7'h7F, 7'h00);
      #12;
      check("reset", 1, 0, DEFD);
      @(negedge HCLK);
      HRESETn = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge HCLK);
         drive(vecs[i].sel, vecs[i].trans, vecs[i].rdy, vecs[i].rsp);
         #2;
         check($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_rsp, vecs[i].e_data);
      end

      // Back-to-back errors, reset asserted during the second ERR1
      @(negedge HCLK); drive(8'h80, 2'b10, 7'h7F, 7'h00); #2; check("b2b_addr", 1, 0, DEFD);
      @(negedge HCLK); #2; check("b2b_err1a", 0, 1, DEFD);
      @(negedge HCLK); #2; check("b2b_err2a", 1, 1, DEFD);
      @(negedge HCLK); drive(8'h00, 2'b00, 7'h7F, 7'h00); #2; check("b2b_err1b", 0, 1, DEFD);
      HRESETn = 1'b0;
      #1; check("reset_mid", 1, 0, DEFD);
      @(negedge HCLK); HRESETn = 1'b1; #2; check("post_reset", 1, 0, DEFD);
      @(negedge HCLK); drive(8'h01, 2'b10, 7'h7F, 7'h00); #2; check("clean_addr", 1, 0, DEFD);
      @(negedge HCLK); drive(8'h00, 2'b00, 7'h7F, 7'h00); #2; check("clean_data", 1, 0, 32'hDEADBEEF);
      @(negedge HCLK); #2; check("clean_idle", 1, 0, DEFD);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
